// File: rtl/mac_pkg.sv
// mac_pkg: shared widths and FSM state type for the MAC feeder.
package mac_pkg;
  localparam int BW = 4;
  localparam int PSUM_BW = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/mac_feeder_fifo.sv
// mac_feeder_fifo: 4-entry valid/ready FIFO; push_ready comes from the registered count only.
module mac_feeder_fifo #(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [w-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [w-1:0] pop_data
);
  logic [w-1:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  logic push, pop;
  always_comb begin
    push_ready = cnt != 3'd4 && !reset;
    pop_valid = cnt != 3'd0;
    push = push_valid && push_ready;
    pop = pop_ready && pop_valid;
    pop_data = mem[rp];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + 2'(push);
      rp <= rp + 2'(pop);
      cnt <= cnt + 3'(push) - 3'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= push_data;
endmodule

// File: rtl/mac_feeder.sv
// mac_feeder: feeds len operand pairs through an external MAC and accumulates the dot product.
// Define MAC_FEEDER_FIFO_EN to buffer input pairs in a 4-entry FIFO.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int bw = BW,
  parameter int psum_bw = PSUM_BW,
  parameter int len = 10,
  parameter int mac_lat = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [bw-1:0]      in_a,
  input  logic [bw-1:0]      in_b,
  output logic [bw-1:0]      mac_a,
  output logic [bw-1:0]      mac_b,
  output logic [psum_bw-1:0] mac_c,
  input  logic [psum_bw-1:0] mac_out,
  output logic               out_valid,
  output logic [psum_bw-1:0] out_psum,
  output logic               busy
);
  localparam int cw = $clog2(len + 1);
  localparam int ww = $clog2(mac_lat + 2);
  state_t state, state_n;
  logic [cw-1:0] cnt;
  logic [ww-1:0] wcnt;
  logic [psum_bw-1:0] acc;
  logic [bw-1:0] pair_a, pair_b;
  logic pair_avail, take, wait_last, cnt_last, out_valid_r;
`ifdef MAC_FEEDER_FIFO_EN
  mac_feeder_fifo #(.w(2 * bw)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  ({in_a, in_b}),
    .pop_valid  (pair_avail),
    .pop_ready  (take),
    .pop_data   ({pair_a, pair_b})
  );
`else
  assign pair_avail = in_valid;
  assign pair_a = in_a;
  assign pair_b = in_b;
  assign in_ready = state == ISSUE && !reset;
`endif
  assign take = state == ISSUE && pair_avail;
  assign wait_last = state == WAIT && wcnt == ww'(mac_lat);
  assign cnt_last = cnt == cw'(len - 1);
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb
    state_n = state == IDLE  ? (start ? ISSUE : IDLE) :
              state == ISSUE ? (take ? WAIT : ISSUE) :
              state == WAIT  ? (wait_last ? (cnt_last ? DONE : ISSUE) : WAIT) :
                               IDLE;
  always_comb begin
    busy = state != IDLE && !reset;
    out_valid = out_valid_r && !reset;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
      wcnt <= '0;
      mac_a <= '0;
      mac_b <= '0;
      mac_c <= '0;
      out_valid_r <= 1'b0;
      out_psum <= '0;
    end else begin
      out_valid_r <= state == DONE;
      if (state == DONE) out_psum <= acc;
      if (state == IDLE && start) begin
        acc <= '0;
        cnt <= '0;
      end
      if (take) begin
        mac_a <= pair_a;
        mac_b <= pair_b;
        mac_c <= acc;
        wcnt <= '0;
      end
      if (state == WAIT) wcnt <= wcnt + ww'(1);
      if (wait_last) begin
        acc <= mac_out;
        cnt <= cnt + cw'(1);
      end
    end
  end
endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: table-driven and randomized dot products against a sum-of-products reference.
module tb_mac_feeder;
  localparam int len = 10;
  typedef logic [3:0] pairs_t [len];
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [15:0] exp_psum;
    int exp_lat;
  } vec_t;
  logic clk = 0;
  logic reset, start, in_valid, in_ready, out_valid, busy;
  logic [3:0] in_a, in_b, mac_a, mac_b;
  logic [15:0] mac_c, mac_out, out_psum;
  logic b_reset, b_start, b_in_ready, b_out_valid, b_busy;
  logic [3:0] b_mac_a, b_mac_b;
  logic [15:0] b_mac_c, b_mac_out, b_out_psum;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mac_feeder #(.bw(4), .psum_bw(16), .len(len), .mac_lat(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_out(mac_out), .out_valid(out_valid), .out_psum(out_psum), .busy(busy)
  );
  mac_feeder #(.bw(4), .psum_bw(16), .len(300), .mac_lat(1)) u_big (
    .clk(clk), .reset(b_reset), .start(b_start), .in_valid(1'b1), .in_ready(b_in_ready),
    .in_a(4'd15), .in_b(4'h8), .mac_a(b_mac_a), .mac_b(b_mac_b), .mac_c(b_mac_c),
    .mac_out(b_mac_out), .out_valid(b_out_valid), .out_psum(b_out_psum), .busy(b_busy)
  );
  // Downstream MAC with one cycle of latency: unsigned a times signed b plus c.
  always_ff @(posedge clk) begin
    mac_out <= 16'(int'(mac_a) * int'($signed(mac_b)) + int'(mac_c));
    b_mac_out <= 16'(int'(b_mac_a) * int'($signed(b_mac_b)) + int'(b_mac_c));
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] ref_dot(input pairs_t av, input pairs_t bv);
    int s = 0;
    for (int i = 0; i < len; i++) s += int'(av[i]) * int'($signed(bv[i]));
    return 16'(s);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_dot(input pairs_t av, input pairs_t bv, input int gap_at, input int gap_len,
                         input int restart_at, output logic [15:0] psum, output int lat);
    int idx, n, gap;
    bit fire, hole;
    idx = 0; n = 0; gap = gap_len; lat = -1; psum = '0;
    start = 1; in_valid = 1; in_a = av[0]; in_b = bv[0];
    while (lat < 0 && n < 2000) begin
      fire = in_valid && in_ready;
      hole = !in_valid && in_ready;
      tick();
      if (fire) idx++;
      if (hole && gap > 0) gap--;
      if (out_valid) begin
        lat = n;
        psum = out_psum;
      end
      n++;
      start = n == restart_at;
      in_valid = idx < len && !(idx == gap_at && gap > 0);
      if (idx < len) begin
        in_a = av[idx];
        in_b = bv[idx];
      end
    end
    start = 0;
    in_valid = 0;
    check("dot_completed", 32'(lat >= 0), 1);
  endtask
  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask
  initial begin
    vec_t tbl[5];
    pairs_t av, bv;
    logic [15:0] psum;
    int lat, pulses, busy_seen, n;
    tbl[0] = '{4'd15, 4'h8, 16'hFB50, 31};
    tbl[1] = '{4'd1, 4'd1, 16'd10, 31};
    tbl[2] = '{4'd0, 4'd7, 16'd0, 31};
    tbl[3] = '{4'd15, 4'd7, 16'd1050, 31};
    tbl[4] = '{4'd8, 4'hF, 16'hFFB0, 31};
    start = 0; in_valid = 0; in_a = 0; in_b = 0; b_start = 0; b_reset = 1;
    reset = 1;
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_mac_abc", {mac_a, mac_b, mac_c}, 0);
    check("rst_out_psum", 32'(out_psum), 0);
    reset = 0;
    tick();
    check("idle_busy", 32'(busy), 0);
    foreach (tbl[t]) begin
      for (int i = 0; i < len; i++) begin
        av[i] = tbl[t].a;
        bv[i] = tbl[t].b;
      end
      run_dot(av, bv, -1, 0, -1, psum, lat);
      check($sformatf("tbl%0d_psum", t), 32'(psum), 32'(tbl[t].exp_psum));
      check($sformatf("tbl%0d_lat", t), lat, tbl[t].exp_lat);
      tick();
      check($sformatf("tbl%0d_strobe_one_cycle", t), 32'(out_valid), 0);
      check($sformatf("tbl%0d_psum_held", t), 32'(out_psum), 32'(tbl[t].exp_psum));
    end
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < len; i++) begin
        av[i] = 4'($urandom);
        bv[i] = 4'($urandom);
      end
      run_dot(av, bv, $urandom_range(1, 9), $urandom_range(0, 3), -1, psum, lat);
      check($sformatf("rand%0d_psum", r), 32'(psum), 32'(ref_dot(av, bv)));
    end
    for (int i = 0; i < len; i++) begin
      av[i] = 4'd15;
      bv[i] = 4'h8;
    end
`ifndef MAC_FEEDER_FIFO_EN
    run_dot(av, bv, 5, 5, -1, psum, lat);
    check("gap_psum", 32'(psum), 32'hFB50);
    check("gap_lat", lat, 36);
`endif
    run_dot(av, bv, -1, 0, 5, psum, lat);
    check("restart_psum", 32'(psum), 32'hFB50);
    pulses = 0; busy_seen = 0;
    repeat (40) begin
      tick();
      pulses += int'(out_valid);
      busy_seen += int'(busy);
    end
    check("restart_extra_pulses", pulses, 0);
    check("restart_busy_after", busy_seen, 0);
    start = 1; in_valid = 1; in_a = 4'd15; in_b = 4'h8;
    for (int e = 0; e <= 10; e++) begin
      tick();
      start = 0;
    end
    check("mid_wait_busy", 32'(busy), 1);
    reset = 1;
    in_valid = 0;
    #1;
    check("reset_busy_comb", 32'(busy), 0);
    check("reset_in_ready_comb", 32'(in_ready), 0);
    tick();
    check("reset_mac_c", 32'(mac_c), 0);
    check("reset_out_psum", 32'(out_psum), 0);
    reset = 0;
    for (int i = 0; i < len; i++) begin
      av[i] = 4'd1;
      bv[i] = 4'd1;
    end
    run_dot(av, bv, -1, 0, -1, psum, lat);
    check("after_reset_psum", 32'(psum), 10);
`ifdef MAC_FEEDER_FIFO_EN
    begin
      logic [3:0] seen [$];
      logic [3:0] prev;
      do_reset();
      for (int i = 0; i < 4; i++) begin
        in_valid = 1; in_a = 4'(i + 1); in_b = 4'd1;
        #1;
        check($sformatf("fifo_ready%0d", i), 32'(in_ready), 1);
        tick();
      end
      in_a = 4'd9;
      check("fifo_full_ready", 32'(in_ready), 0);
      in_valid = 0;
      start = 1;
      prev = mac_a;
      for (int c = 0; c < 40; c++) begin
        tick();
        start = 0;
        if (mac_a != prev) seen.push_back(mac_a);
        prev = mac_a;
      end
      check("fifo_pops", seen.size(), 4);
      for (int i = 0; i < 4 && i < seen.size(); i++)
        check($sformatf("fifo_order%0d", i), 32'(seen[i]), i + 1);
      do_reset();
    end
`endif
    b_reset = 0;
    b_start = 1;
    lat = -1;
    n = 0;
    while (lat < 0 && n < 2000) begin
      tick();
      b_start = 0;
      if (b_out_valid) lat = n;
      n++;
    end
    check("wrap_lat", lat, 901);
    check("wrap_psum", 32'(b_out_psum), 32'h7360);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameter bw, default 4, activation/weight width.
REQ-002 Parameter psum_bw, default 16, partial-sum width.
REQ-003 Parameter len, default 10, pairs per dot product (>=1).
REQ-004 Parameter mac_lat, default 1, cycles from mac_a/mac_b/mac_c visible to mac_out valid in the downstream MAC (>=1).
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 start  input  1  pulse; begins one dot product.
REQ-008 in_valid  input  1  pair available.
REQ-009 in_ready  output  1  pair accepted when in_valid & in_ready.
REQ-010 in_a  input  bw  activation, unsigned.
REQ-011 in_b  input  bw  weight, two's complement.
REQ-012 mac_a, mac_b  output  bw  registered operands to downstream MAC.
REQ-013 mac_c  output  psum_bw  registered running psum to downstream MAC.
REQ-014 mac_out  input  psum_bw  MAC result a*b+c.
REQ-015 out_valid  output  1  one-cycle result strobe.
REQ-016 out_psum  output  psum_bw  final psum, held until next out_valid.
REQ-017 busy  output  1  high whenever state != IDLE.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, DONE.
REQ-019 IDLE: start -> ISSUE; acc and pair count cleared to 0; start ignored in any other state.
REQ-020 ISSUE: on available pair, mac_a/mac_b <= pair, mac_c <= acc, -> WAIT; no pair -> stay ISSUE, outputs held.
REQ-021 WAIT lasts exactly mac_lat+1 cycles; on its last cycle acc <= mac_out, count increments.
REQ-022 WAIT exit: count reaches len -> DONE, else -> ISSUE.
REQ-023 DONE: out_valid=1, out_psum=acc, one cycle, -> IDLE.
REQ-024 Per-pair cost mac_lat+2 cycles; with pairs always available out_valid asserts len*(mac_lat+2)+1 cycles after start sampled (31 at defaults).
REQ-025 Psum arithmetic wraps modulo 2^psum_bw; no saturation, no overflow flag.
REQ-026 Pairs beyond len are not consumed; they remain for the next start.

Reset
REQ-027 reset (any state, including mid-WAIT) -> IDLE, acc/count 0, FIFO emptied, mac_a/mac_b/mac_c/out_psum 0, out_valid/busy/in_ready 0 during reset.

Configuration
REQ-028 Macro MAC_FEEDER_FIFO_EN defined: 4-entry input FIFO; in_ready = FIFO not full in every state (incl. IDLE); ISSUE consumes FIFO head.
REQ-029 MAC_FEEDER_FIFO_EN undefined: no storage; in_ready=1 only in ISSUE; pair taken directly from in_a/in_b.
REQ-030 Simultaneous FIFO push and pop when full: pop first, push accepted only if in_ready was high (in_ready depends on registered full only).

Structure
REQ-031 Package mac_pkg: default bw/psum_bw constants, FSM state typedef.
REQ-032 One sub-module mac_feeder_fifo (4-entry, valid/ready), instantiated only under MAC_FEEDER_FIFO_EN.

Verification
REQ-033 Defaults, bench MAC model, 10 pairs a=15,b=-8 -> out_psum=16'hFB50, out_valid at cycle 31 after start.
REQ-034 len=300, a=15,b=-8 -> wrapped out_psum=16'h7360.
REQ-035 in_valid dropped 5 cycles mid-vector -> FSM holds ISSUE, result unchanged, latency +5.
REQ-036 reset asserted during WAIT of pair 4, then fresh start with 10 pairs a=1,b=1 -> out_psum=16'd10.
REQ-037 start pulsed while busy -> ignored, single out_valid.
REQ-038 FIFO_EN: 4 pairs pushed in IDLE, 5th -> in_ready=0; after start all 4 consumed in order (mac_a sequence checked).
